spi_rx_deserializer: RTL and testbench
======================================

// Module: spi_rx_deserializer
// PURPOSE
//  Slave-side receiver downstream of the SPI master (spi_protocol): captures spi_cs_l/spi_sclk/spi_data,
//  deserializes MSB-first frames into DATA_W-bit words in the clk domain, and presents them on a
//  valid/ready output port. Flags overrun (word lost) and framing errors (CS released mid-word).
// PARAMETERS
//  DATA_W       16  bits per word; also max bits per CS-low burst before wrap to next word
//  SYNC_STAGES  2   flops in each input synchronizer (>=2)
//  CNT_W        5   width of bit_cnt; must satisfy 2**CNT_W > DATA_W
// PORTS
//  clk          in   1       system clock; all logic on rising edge
//  reset        in   1       asynchronous, active-low reset
//  spi_cs_l     in   1       chip select from master, active-low, asynchronous to clk
//  spi_sclk     in   1       serial clock from master, idle low, asynchronous to clk
//  spi_data     in   1       serial data (MOSI), MSB first
//  rx_data      out  DATA_W  received word; stable while rx_valid=1
//  rx_valid     out  1       word available
//  rx_ready     in   1       consumer accepts word when rx_valid&&rx_ready
//  ovr_clr      in   1       one-cycle pulse clears rx_overrun
//  rx_overrun   out  1       sticky: completed word dropped because output was full
//  rx_frame_err out  1       one-cycle pulse: CS deasserted with 1..DATA_W-1 bits shifted
//  rx_busy      out  1       1 while FSM in SHIFT
//  bit_cnt      out  CNT_W   bits shifted into current word
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, rx_data=0, shift reg=0, sync flops=idle (cs_l=1, sclk=0), FSM=IDLE.
//  Sync: each of cs_l/sclk/data through SYNC_STAGES flops; sclk rise = synced & ~prev; cs fall/rise likewise.
//  SPI mode 0 only: sample spi_data on sclk rising edge. Requirement: sclk high/low each >= 2 clk periods.
//  FSM:
//   IDLE : cs fall -> SHIFT, bit_cnt=0. sclk edges ignored while cs_l=1.
//   SHIFT: sclk rise -> shreg={shreg[DATA_W-2:0],data_s}, bit_cnt+1.
//          bit_cnt==DATA_W-1 on rise -> word complete: bit_cnt=0, stay SHIFT (back-to-back words allowed).
//          cs rise -> IDLE; if bit_cnt!=0 pulse rx_frame_err, discard partial bits; bit_cnt=0.
//  Word complete handling (same cycle as last sclk rise detected):
//   output empty, or rx_valid&&rx_ready this cycle -> rx_data<=word, rx_valid<=1 next cycle (no bubble).
//   rx_valid&&!rx_ready -> word dropped, rx_data unchanged, rx_overrun<=1.
//  rx_valid clears on accept unless replaced as above. ovr_clr and new overrun same cycle -> overrun stays 1.
//  Latency: rx_valid rises SYNC_STAGES+2 clk edges after the final sclk rising edge is first sampled.
//  cs rise and final sclk rise in same cycle: word completes first (valid), no frame_err.
//  Reset mid-frame: partial word discarded, no flags; next frame starts only on a fresh cs fall.
// STRUCTURE
//  spi_pkg: DATA_W default, state typedef {IDLE,SHIFT}, idle-level constants for cs_l/sclk.
//  Sub-module spi_sync_edge (SYNC_STAGES synchronizer + rise/fall detect, param reset value),
//  instantiated for spi_cs_l and spi_sclk; spi_data uses synchronizer output only.
//  Top holds FSM, shift reg, bit counter, output register, flags.
// TESTING
//  1 Drive spi_protocol with data_in=16'h5555, rx_ready=1 -> one rx_valid pulse, rx_data=16'h5555, no flags.
//  2 Then data_in=16'h1234 -> rx_data=16'h1234; bit_cnt steps 0..15 then returns 0.
//  3 rx_ready=0, two back-to-back frames A5A5,0F0F -> rx_data stays A5A5, rx_overrun=1; ovr_clr -> 0.
//  4 CS released after 7 bits -> rx_frame_err one-cycle pulse, rx_valid stays 0, next frame 16'hBEEF ok.
//  5 32 sclks in one CS-low burst, 16'hCAFE then 16'hF00D, rx_ready=1 -> two words in order.
//  6 Assert reset (low) after 9 bits -> outputs 0; fresh frame 16'h8001 -> rx_data=16'h8001.

Source files
------------

// File: rtl/spi_pkg.sv
// ----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI slave receive path.
//   DATA_W_DEF  : default word width in bits
//   state_t     : receiver FSM states (IDLE waits for chip select, SHIFT collects bits)
//   CS_IDLE     : level of spi_cs_l when no transfer is in progress
//   SCLK_IDLE   : level of spi_sclk between transfers (mode 0 idles low)
// ----------------------------------------------------------------------------
package spi_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam logic CS_IDLE   = 1'b1;
   localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// ----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous input into the clk domain through a SYNC_STAGES-deep
// flop chain, then produces registered single-cycle rise and fall pulses.
//   clk      in   system clock
//   reset    in   asynchronous, active-low reset
//   i_async  in   raw asynchronous input
//   o_rise   out  one-cycle pulse after a synchronized 0->1 transition
//   o_fall   out  one-cycle pulse after a synchronized 1->0 transition
// RESET_VAL is the idle level of the input, so leaving reset never produces
// a spurious edge while the input sits at its idle level.
// ----------------------------------------------------------------------------
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RESET_VAL   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_level;

   assign w_level = r_sync[SYNC_STAGES-1];

   // Synchronizer chain followed by a registered edge detector; the edge
   // pulses are registered so they are glitch-free for the consuming FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync <= {SYNC_STAGES{RESET_VAL}};
         r_prev <= RESET_VAL;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= w_level;
         r_rise <= w_level & ~r_prev;
         r_fall <= ~w_level & r_prev;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/spi_rx_deserializer.sv
// ----------------------------------------------------------------------------
// spi_rx_deserializer
// SPI mode-0 slave receiver: samples MOSI on sclk rising edges while chip
// select is low, assembles MSB-first words and hands them out on a
// valid/ready port in the clk domain.
//   clk, reset           system clock, asynchronous active-low reset
//   spi_cs_l/sclk/data   raw SPI pins from the master (asynchronous)
//   rx_data/rx_valid     received word and its valid flag
//   rx_ready             consumer accepts the word when rx_valid && rx_ready
//   ovr_clr              one-cycle pulse that clears rx_overrun
//   rx_overrun           sticky: a completed word was dropped (output full)
//   rx_frame_err         one-cycle pulse: chip select released mid-word
//   rx_busy              high while the FSM is collecting bits
//   bit_cnt              bits shifted into the word in progress
// ----------------------------------------------------------------------------
module spi_rx_deserializer
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              spi_cs_l,
   input  logic              spi_sclk,
   input  logic              spi_data,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   input  logic              ovr_clr,
   output logic              rx_overrun,
   output logic              rx_frame_err,
   output logic              rx_busy,
   output logic [CNT_W-1:0]  bit_cnt
);

   state_t              r_state;
   logic [DATA_W-1:0]   r_shreg;
   logic [CNT_W-1:0]    r_bitCnt;
   logic [DATA_W-1:0]   r_rxData;
   logic                r_rxValid;
   logic                r_overrun;
   logic                r_frameErr;
   logic [SYNC_STAGES:0] r_dataSync;

   logic                w_csRise;
   logic                w_csFall;
   logic                w_sclkRise;
   logic                w_unusedSclkFall;
   logic                w_dataS;
   logic                w_lastBit;
   logic                w_wordDone;
   logic                w_outFree;
   logic                w_partial;
   logic [DATA_W-1:0]   w_word;
   logic [CNT_W-1:0]    w_cntInc;

   // Chip select idles high, sclk idles low; falling sclk edges carry no
   // meaning in mode 0, so that pulse is left unused.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE)) u_csSync (
      .clk     (clk),
      .reset   (reset),
      .i_async (spi_cs_l),
      .o_rise  (w_csRise),
      .o_fall  (w_csFall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sclkSync (
      .clk     (clk),
      .reset   (reset),
      .i_async (spi_sclk),
      .o_rise  (w_sclkRise),
      .o_fall  (w_unusedSclkFall)
   );

   // Data needs one extra stage beyond the synchronizer so it lines up with
   // the registered edge pulses coming out of spi_sync_edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dataSync <= '0;
      end else begin
         r_dataSync <= {r_dataSync[SYNC_STAGES-1:0], spi_data};
      end
   end

   assign w_dataS    = r_dataSync[SYNC_STAGES];
   assign w_word     = {r_shreg[DATA_W-2:0], w_dataS};
   assign w_cntInc   = r_bitCnt + CNT_W'(1);
   assign w_lastBit  = (r_bitCnt == CNT_W'(DATA_W-1));
   assign w_wordDone = (r_state == SHIFT) && w_sclkRise && w_lastBit;
   assign w_outFree  = !r_rxValid || rx_ready;
   // Bits left in the word if chip select rises this cycle; a simultaneous
   // final sclk rise completes the word, so it is not counted as partial.
   assign w_partial  = w_sclkRise ? !w_lastBit : (r_bitCnt != '0);

   // Output register and flags: a completed word replaces the held one when
   // the slot is empty or being accepted this same cycle, otherwise it is
   // dropped and recorded as an overrun (which wins over ovr_clr).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rxData   <= '0;
         r_rxValid  <= 1'b0;
         r_overrun  <= 1'b0;
      end else begin
         if (w_wordDone && w_outFree) begin
            r_rxData  <= w_word;
            r_rxValid <= 1'b1;
         end else if (r_rxValid && rx_ready) begin
            r_rxValid <= 1'b0;
         end

         if (w_wordDone && !w_outFree) begin
            r_overrun <= 1'b1;
         end else if (ovr_clr) begin
            r_overrun <= 1'b0;
         end
      end
   end

   // Receive FSM: IDLE waits for a chip-select fall; SHIFT collects bits,
   // wraps the counter after each full word and returns to IDLE when chip
   // select is released, flagging a framing error on a partial word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_shreg    <= '0;
         r_bitCnt   <= '0;
         r_frameErr <= 1'b0;
      end else begin
         r_frameErr <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_csFall) begin
                  r_state  <= SHIFT;
                  r_bitCnt <= '0;
               end
            end
            SHIFT: begin
               if (w_sclkRise) begin
                  r_shreg  <= w_word;
                  r_bitCnt <= w_lastBit ? '0 : w_cntInc;
               end
               if (w_csRise) begin
                  r_state    <= IDLE;
                  r_bitCnt   <= '0;
                  r_shreg    <= '0;
                  r_frameErr <= w_partial;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign rx_data      = r_rxData;
   assign rx_valid     = r_rxValid;
   assign rx_overrun   = r_overrun;
   assign rx_frame_err = r_frameErr;
   assign rx_busy      = (r_state == SHIFT);
   assign bit_cnt      = r_bitCnt;

endmodule

// File: tb/tb_spi_rx_deserializer.sv
// ----------------------------------------------------------------------------
// tb_spi_rx_deserializer
// Drives the receiver like an SPI mode-0 master. Stimulus pushes each word it
// expects to see delivered into a queue; an independent monitor pops and
// compares whenever the DUT hands over a word (rx_valid && rx_ready).
// ----------------------------------------------------------------------------
module tb_spi_rx_deserializer;

   localparam int DATA_W      = 16;
   localparam int CNT_W       = 5;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic              spi_cs_l;
   logic              spi_sclk;
   logic              spi_data;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              ovr_clr;
   logic              rx_overrun;
   logic              rx_frame_err;
   logic              rx_busy;
   logic [CNT_W-1:0]  bit_cnt;

   int nVectors       = 0;
   int nMiscompares   = 0;
   int frameErrCycles = 0;
   logic [DATA_W-1:0] expQ[$];

   always #5 clk = ~clk;

   spi_rx_deserializer #(
      .DATA_W      (DATA_W),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .spi_cs_l     (spi_cs_l),
      .spi_sclk     (spi_sclk),
      .spi_data     (spi_data),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .ovr_clr      (ovr_clr),
      .rx_overrun   (rx_overrun),
      .rx_frame_err (rx_frame_err),
      .rx_busy      (rx_busy),
      .bit_cnt      (bit_cnt)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (reset === 1'b1) begin
         if (rx_frame_err) frameErrCycles++;
         if (rx_valid && rx_ready) begin
            if (expQ.size() == 0) begin
               nVectors++;
               nMiscompares++;
               $display("[TB] FAIL unexpected word: got 0x%0h, expected none", rx_data);
            end else begin
               checkOutput("rx_data", {16'h0, rx_data}, {16'h0, expQ.pop_front()});
            end
         end
      end
   end

   // Drivers change inputs 2 ns after a rising edge.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic spiBit(input logic b);
      spi_data = b;
      waitCycles(HALF);
      spi_sclk = 1'b1;
      waitCycles(HALF);
      spi_sclk = 1'b0;
   endtask

   task automatic csAssert();
      spi_cs_l = 1'b0;
      waitCycles(HALF);
   endtask

   task automatic csRelease();
      waitCycles(HALF);
      spi_cs_l = 1'b1;
      waitCycles(2 * HALF);
   endtask

   task automatic applyStimulus(input logic [DATA_W-1:0] word, input int nBits, input bit expectWord);
      if (expectWord) expQ.push_back(word);
      for (int i = 0; i < nBits; i++) spiBit(word[DATA_W-1-i]);
   endtask

   task automatic sendFrame(input logic [DATA_W-1:0] word, input bit expectWord);
      csAssert();
      applyStimulus(word, DATA_W, expectWord);
      csRelease();
   endtask

   task automatic waitDrain();
      int k = 0;
      while (expQ.size() != 0 && k < 200) begin
         waitCycles(1);
         k++;
      end
      checkOutput("drain queue", expQ.size(), 0);
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int snap;
      logic [DATA_W-1:0] w;
      reset    = 1'b0;
      spi_cs_l = 1'b1;
      spi_sclk = 1'b0;
      spi_data = 1'b0;
      rx_ready = 1'b1;
      ovr_clr  = 1'b0;
      waitCycles(3);
      checkOutput("reset rx_valid",  rx_valid, 0);
      checkOutput("reset rx_data",   rx_data, 0);
      checkOutput("reset bit_cnt",   bit_cnt, 0);
      checkOutput("reset rx_busy",   rx_busy, 0);
      checkOutput("reset overrun",   rx_overrun, 0);
      checkOutput("reset frame_err", rx_frame_err, 0);
      reset = 1'b1;
      waitCycles(5);

      $display("[TB] test 1: single word 5555");
      sendFrame(16'h5555, 1'b1);
      waitDrain();
      checkOutput("t1 overrun", rx_overrun, 0);
      checkOutput("t1 frame_err count", frameErrCycles, 0);

      $display("[TB] test 2: word 1234 with bit_cnt stepping");
      w = 16'h1234;
      expQ.push_back(w);
      csAssert();
      checkOutput("t2 busy", rx_busy, 1);
      checkOutput("t2 bit_cnt start", bit_cnt, 0);
      for (int i = 0; i < DATA_W; i++) begin
         spi_data = w[DATA_W-1-i];
         waitCycles(HALF);
         spi_sclk = 1'b1;
         waitCycles(HALF);
         checkOutput("t2 bit_cnt step", bit_cnt, (i + 1) % DATA_W);
         spi_sclk = 1'b0;
      end
      csRelease();
      waitDrain();
      checkOutput("t2 busy after", rx_busy, 0);

      $display("[TB] test 3: overrun with rx_ready low");
      rx_ready = 1'b0;
      sendFrame(16'hA5A5, 1'b1);
      sendFrame(16'h0F0F, 1'b0);
      waitCycles(10);
      checkOutput("t3 rx_valid held", rx_valid, 1);
      checkOutput("t3 rx_data held", rx_data, 16'hA5A5);
      checkOutput("t3 overrun set", rx_overrun, 1);
      ovr_clr = 1'b1;
      waitCycles(1);
      ovr_clr = 1'b0;
      checkOutput("t3 overrun cleared", rx_overrun, 0);
      rx_ready = 1'b1;
      waitDrain();
      waitCycles(2);
      checkOutput("t3 rx_valid after accept", rx_valid, 0);

      $display("[TB] test 4: framing error after 7 bits");
      snap = frameErrCycles;
      csAssert();
      applyStimulus(16'hB000, 7, 1'b0);
      csRelease();
      checkOutput("t4 frame_err pulse cycles", frameErrCycles - snap, 1);
      checkOutput("t4 rx_valid", rx_valid, 0);
      sendFrame(16'hBEEF, 1'b1);
      waitDrain();
      checkOutput("t4 frame_err after good frame", frameErrCycles - snap, 1);

      $display("[TB] test 5: two words in one burst");
      csAssert();
      applyStimulus(16'hCAFE, DATA_W, 1'b1);
      applyStimulus(16'hF00D, DATA_W, 1'b1);
      csRelease();
      waitDrain();
      checkOutput("t5 overrun", rx_overrun, 0);

      $display("[TB] test 6: reset mid-frame");
      snap = frameErrCycles;
      csAssert();
      applyStimulus(16'hFFFF, 9, 1'b0);
      reset = 1'b0;
      waitCycles(1);
      checkOutput("t6 rx_valid", rx_valid, 0);
      checkOutput("t6 rx_data", rx_data, 0);
      checkOutput("t6 bit_cnt", bit_cnt, 0);
      checkOutput("t6 rx_busy", rx_busy, 0);
      spi_cs_l = 1'b1;
      waitCycles(3);
      reset = 1'b1;
      waitCycles(5);
      checkOutput("t6 overrun", rx_overrun, 0);
      sendFrame(16'h8001, 1'b1);
      waitDrain();
      checkOutput("t6 no frame_err", frameErrCycles - snap, 0);

      waitCycles(5);
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
